// File: rtl/inst_frontend_if.sv
// Bundle between the instruction source and the frontend: the instruction word
// and OFIFO status flow in, SRAM controls, datapath strobes, errors and counters flow out.
interface inst_frontend_if #(
    parameter int ADDR_W = 11
);
    logic [63:0]       inst;
    logic              ofifo_valid;
    logic              xmem_cen_n;
    logic              xmem_wen_n;
    logic [ADDR_W-1:0] xmem_a;
    logic              pmem_cen_n;
    logic              pmem_wen_n;
    logic [ADDR_W-1:0] pmem_a;
    logic              l0_wr;
    logic              l0_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              ofifo_rd;
    logic              execute;
    logic              load;
    logic              acc;
    logic              sfu_passthrough;
    logic              pmem_ren;
    logic              debug;
    logic [3:0]        err;
    logic [7:0]        exec_cnt;
    logic [7:0]        orow_cnt;

    modport master (
        output inst, ofifo_valid,
        input  xmem_cen_n, xmem_wen_n, xmem_a, pmem_cen_n, pmem_wen_n, pmem_a,
               l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd, execute, load,
               acc, sfu_passthrough, pmem_ren, debug, err, exec_cnt, orow_cnt
    );

    modport slave (
        input  inst, ofifo_valid,
        output xmem_cen_n, xmem_wen_n, xmem_a, pmem_cen_n, pmem_wen_n, pmem_a,
               l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd, execute, load,
               acc, sfu_passthrough, pmem_ren, debug, err, exec_cnt, orow_cnt
    );
endinterface

// File: rtl/inst_frontend.sv
// Instruction frontend: registers the instruction word onto the datapath strobes,
// delays psum writes to line up with the SFU pipeline, and tracks errors and counts.
module inst_frontend #(
    parameter int SFU_LAT = 1,
    parameter int ADDR_W  = 11
) (
    input logic           clk,
    input logic           reset,
    inst_frontend_if.slave bus
);

    logic [63:0]       inst;
    logic              pm_rd;
    logic              pm_wr;
    logic              ofifo_rd_ok;
    logic              head_vld;
    logic [ADDR_W-1:0] head_addr;
    logic              collision;
    logic              unused_inst_bits;

    logic [SFU_LAT-1:0] dl_vld;
    logic [ADDR_W-1:0]  dl_addr [SFU_LAT];

    assign inst             = bus.inst;
    assign pm_rd            = !inst[32] && !inst[31];
    assign pm_wr            = !inst[32] && inst[31];
    assign ofifo_rd_ok      = inst[6] && bus.ofifo_valid;
    assign head_vld         = dl_vld[SFU_LAT-1];
    assign head_addr        = dl_addr[SFU_LAT-1];
    assign collision        = head_vld && pm_rd;
    assign unused_inst_bits = ^inst[62:36];

    // Psum write delay line: one slot per SFU stage, shifts every cycle so
    // back-to-back writes emerge in order without loss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_vld <= '0;
            for (int i = 0; i < SFU_LAT; i++) dl_addr[i] <= '0;
        end else begin
            dl_vld[0]  <= pm_wr;
            dl_addr[0] <= ADDR_W'(inst[30:20]);
            for (int i = 1; i < SFU_LAT; i++) begin
                dl_vld[i]  <= dl_vld[i-1];
                dl_addr[i] <= dl_addr[i-1];
            end
        end
    end

    // Stage-1 forwarding of xmem controls and datapath strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.xmem_cen_n      <= 1'b1;
            bus.xmem_wen_n      <= 1'b1;
            bus.xmem_a          <= '0;
            bus.l0_wr           <= 1'b0;
            bus.l0_rd           <= 1'b0;
            bus.ififo_wr        <= 1'b0;
            bus.ififo_rd        <= 1'b0;
            bus.ofifo_rd        <= 1'b0;
            bus.execute         <= 1'b0;
            bus.load            <= 1'b0;
            bus.acc             <= 1'b0;
            bus.sfu_passthrough <= 1'b0;
            bus.debug           <= 1'b0;
        end else begin
            bus.xmem_cen_n      <= inst[19];
            bus.xmem_wen_n      <= inst[18];
            bus.xmem_a          <= ADDR_W'(inst[17:7]);
            bus.l0_wr           <= inst[2];
            bus.l0_rd           <= inst[3];
            bus.ififo_wr        <= inst[5];
            bus.ififo_rd        <= inst[4];
            bus.ofifo_rd        <= ofifo_rd_ok;
            bus.execute         <= inst[1];
            bus.load            <= inst[0];
            bus.acc             <= inst[33];
            bus.sfu_passthrough <= inst[34];
            bus.debug           <= inst[63];
        end
    end

    // Psum port arbitration: a delayed write at the line head beats a fresh read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pmem_cen_n <= 1'b1;
            bus.pmem_wen_n <= 1'b1;
            bus.pmem_a     <= '0;
            bus.pmem_ren   <= 1'b0;
        end else if (head_vld) begin
            bus.pmem_cen_n <= 1'b0;
            bus.pmem_wen_n <= 1'b0;
            bus.pmem_a     <= head_addr;
            bus.pmem_ren   <= 1'b0;
        end else if (pm_rd) begin
            bus.pmem_cen_n <= 1'b0;
            bus.pmem_wen_n <= 1'b1;
            bus.pmem_a     <= ADDR_W'(inst[30:20]);
            bus.pmem_ren   <= inst[35];
        end else begin
            bus.pmem_cen_n <= 1'b1;
            bus.pmem_wen_n <= 1'b1;
            bus.pmem_ren   <= 1'b0;
        end
    end

    // Sticky error flags, accumulated at capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.err <= '0;
        end else begin
            bus.err <= bus.err | {inst[6] && !bus.ofifo_valid,
                                  collision,
                                  !inst[19] && !inst[18] && inst[2],
                                  inst[0] && inst[1]};
        end
    end

    // Saturating execute and OFIFO-row counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.exec_cnt <= '0;
            bus.orow_cnt <= '0;
        end else begin
            if (inst[1] && bus.exec_cnt != 8'hFF) bus.exec_cnt <= bus.exec_cnt + 8'd1;
            if (ofifo_rd_ok && bus.orow_cnt != 8'hFF) bus.orow_cnt <= bus.orow_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_inst_frontend.sv
// Directed bench for inst_frontend with SFU_LAT=1, ADDR_W=11.
module tb_inst_frontend;

    localparam logic [63:0] IDLE = 64'h0000_0001_000C_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    inst_frontend_if #(.ADDR_W(11)) bus ();

    inst_frontend #(.SFU_LAT(1), .ADDR_W(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wr_inst(input int a);
        logic [63:0] v;
        v = IDLE;
        v[32] = 1'b0;
        v[31] = 1'b1;
        v[30:20] = 11'(a);
        return v;
    endfunction

    function automatic logic [63:0] rd_inst(input int a, input logic ren);
        logic [63:0] v;
        v = IDLE;
        v[32] = 1'b0;
        v[31] = 1'b0;
        v[30:20] = 11'(a);
        v[35] = ren;
        return v;
    endfunction

    initial begin
        logic [63:0] v;
        bus.inst = IDLE;
        bus.ofifo_valid = 1'b0;

        // reset state
        step();
        step();
        chk("rst_xmem_cen", 32'(bus.xmem_cen_n), 32'h1);
        chk("rst_xmem_wen", 32'(bus.xmem_wen_n), 32'h1);
        chk("rst_pmem_cen", 32'(bus.pmem_cen_n), 32'h1);
        chk("rst_pmem_wen", 32'(bus.pmem_wen_n), 32'h1);
        chk("rst_addrs", 32'({bus.xmem_a, bus.pmem_a}), 32'h0);
        chk("rst_strobes", 32'({bus.load, bus.execute, bus.l0_wr, bus.ofifo_rd}), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_cnts", 32'({bus.exec_cnt, bus.orow_cnt}), 32'h0);
        reset = 1'b0;

        // load held 16 cycles
        v = IDLE; v[0] = 1'b1;
        bus.inst = v;
        chk("load_before", 32'(bus.load), 32'h0);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("load_high", 32'(bus.load), 32'h1);
        end
        bus.inst = IDLE;
        step();
        chk("load_after", 32'(bus.load), 32'h0);
        chk("load_err", 32'(bus.err), 32'h0);

        // mixed stage-1 fields
        v = IDLE;
        v[19] = 1'b0; v[18] = 1'b1; v[17:7] = 11'h155;
        v[3] = 1'b1; v[5] = 1'b1; v[4] = 1'b1; v[34] = 1'b1; v[63] = 1'b1; v[33] = 1'b1;
        bus.inst = v;
        step();
        bus.inst = IDLE;
        chk("fwd_xmem_cen", 32'(bus.xmem_cen_n), 32'h0);
        chk("fwd_xmem_wen", 32'(bus.xmem_wen_n), 32'h1);
        chk("fwd_xmem_a", 32'(bus.xmem_a), 32'h155);
        chk("fwd_strobes", 32'({bus.l0_rd, bus.ififo_wr, bus.ififo_rd, bus.sfu_passthrough,
                                bus.debug, bus.acc, bus.l0_wr, bus.execute}), 32'hFC);
        chk("fwd_pmem_idle", 32'(bus.pmem_cen_n), 32'h1);

        // write to 5 with acc
        v = wr_inst(5); v[33] = 1'b1;
        bus.inst = v;
        step();
        bus.inst = IDLE;
        chk("wr5_acc", 32'(bus.acc), 32'h1);
        chk("wr5_s1_cen", 32'(bus.pmem_cen_n), 32'h1);
        step();
        chk("wr5_cen_wen", 32'({bus.pmem_cen_n, bus.pmem_wen_n}), 32'h0);
        chk("wr5_a", 32'(bus.pmem_a), 32'h5);
        chk("wr5_acc_off", 32'(bus.acc), 32'h0);
        step();
        chk("wr5_idle_cen", 32'({bus.pmem_cen_n, bus.pmem_wen_n}), 32'h3);
        chk("wr5_a_hold", 32'(bus.pmem_a), 32'h5);

        // plain read of 9
        bus.inst = rd_inst(9, 1'b1);
        step();
        bus.inst = IDLE;
        chk("rd9_cen_wen", 32'({bus.pmem_cen_n, bus.pmem_wen_n}), 32'h1);
        chk("rd9_a", 32'(bus.pmem_a), 32'h9);
        chk("rd9_ren", 32'(bus.pmem_ren), 32'h1);
        chk("rd9_err", 32'(bus.err), 32'h0);

        // collision: write 3 then read 7
        bus.inst = wr_inst(3);
        step();
        bus.inst = rd_inst(7, 1'b1);
        step();
        bus.inst = IDLE;
        chk("col_cen_wen", 32'({bus.pmem_cen_n, bus.pmem_wen_n}), 32'h0);
        chk("col_a", 32'(bus.pmem_a), 32'h3);
        chk("col_ren", 32'(bus.pmem_ren), 32'h0);
        chk("col_err", 32'(bus.err), 32'h4);
        step();
        chk("col_after_cen", 32'(bus.pmem_cen_n), 32'h1);
        chk("col_after_a", 32'(bus.pmem_a), 32'h3);

        // ofifo gating
        v = IDLE; v[6] = 1'b1;
        bus.inst = v;
        bus.ofifo_valid = 1'b0;
        step();
        chk("ofifo_blocked", 32'(bus.ofifo_rd), 32'h0);
        chk("ofifo_err", 32'(bus.err), 32'hC);
        chk("ofifo_cnt0", 32'(bus.orow_cnt), 32'h0);
        bus.ofifo_valid = 1'b1;
        step();
        bus.inst = IDLE;
        chk("ofifo_pulse", 32'(bus.ofifo_rd), 32'h1);
        chk("ofifo_cnt1", 32'(bus.orow_cnt), 32'h1);
        step();
        bus.ofifo_valid = 1'b0;
        chk("ofifo_drop", 32'(bus.ofifo_rd), 32'h0);
        chk("ofifo_cnt_hold", 32'(bus.orow_cnt), 32'h1);

        // back-to-back writes 10, 11, 12
        bus.inst = wr_inst(10);
        step();
        bus.inst = wr_inst(11);
        step();
        chk("b2b_a10", 32'({bus.pmem_cen_n, bus.pmem_wen_n, 11'(bus.pmem_a)}), 32'(11'd10));
        bus.inst = wr_inst(12);
        step();
        bus.inst = IDLE;
        chk("b2b_a11", 32'({bus.pmem_cen_n, bus.pmem_wen_n, 11'(bus.pmem_a)}), 32'(11'd11));
        step();
        chk("b2b_a12", 32'({bus.pmem_cen_n, bus.pmem_wen_n, 11'(bus.pmem_a)}), 32'(11'd12));
        step();
        chk("b2b_idle", 32'(bus.pmem_cen_n), 32'h1);

        // execute saturation
        v = IDLE; v[1] = 1'b1;
        bus.inst = v;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 199) chk("exec_200", 32'(bus.exec_cnt), 32'd200);
        end
        bus.inst = IDLE;
        chk("exec_sat", 32'(bus.exec_cnt), 32'd255);
        chk("exec_strobe", 32'(bus.execute), 32'h1);
        step();
        chk("exec_sat_hold", 32'(bus.exec_cnt), 32'd255);

        // reset with writes in flight
        bus.inst = wr_inst(20);
        step();
        bus.inst = wr_inst(21);
        step();
        bus.inst = wr_inst(22);
        step();
        bus.inst = IDLE;
        chk("inflight_a21", 32'(bus.pmem_a), 32'd21);
        #2 reset = 1'b1;
        #1;
        chk("arst_pmem", 32'({bus.pmem_cen_n, bus.pmem_wen_n}), 32'h3);
        chk("arst_pmem_a", 32'(bus.pmem_a), 32'h0);
        chk("arst_err", 32'(bus.err), 32'h0);
        chk("arst_cnts", 32'({bus.exec_cnt, bus.orow_cnt}), 32'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_wr", 32'({bus.pmem_cen_n, bus.pmem_wen_n}), 32'h3);
        end

        // first instruction after release
        v = IDLE; v[0] = 1'b1;
        bus.inst = v;
        step();
        bus.inst = IDLE;
        chk("first_after_rst", 32'(bus.load), 32'h1);
        chk("first_err", 32'(bus.err), 32'h0);

        // xmem write with l0_wr, then load with execute
        v = IDLE; v[19] = 1'b0; v[18] = 1'b0; v[2] = 1'b1;
        bus.inst = v;
        step();
        chk("err_xmem_l0", 32'(bus.err), 32'h2);
        v = IDLE; v[0] = 1'b1; v[1] = 1'b1;
        bus.inst = v;
        step();
        bus.inst = IDLE;
        chk("err_load_exec", 32'(bus.err), 32'h3);
        chk("fwd_illegal", 32'({bus.load, bus.execute}), 32'h3);
        step();
        chk("err_sticky", 32'(bus.err), 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_frontend.md
INST_FRONTEND -- requirements
Module: inst_frontend

Interface
REQ-001 SHALL have parameter SFU_LAT, default 1, range 1..4: pmem write-delay cycles, matching the SFU pipeline depth.
REQ-002 SHALL have parameter ADDR_W, default 11: xmem/pmem address width.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 inst  input  64  instruction word. Fields: [63] debug, [35] REN_pmem, [34] sfu_passthrough, [33] acc, [32] CEN_pmem (active-low), [31] pmem write request (active-high), [30:20] A_pmem, [19] CEN_xmem (active-low), [18] WEN_xmem (active-low), [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-006 ofifo_valid  input  1  OFIFO holds a complete row.
REQ-007 xmem_cen_n, xmem_wen_n  output  1 each  activation/weight SRAM controls, active-low.
REQ-008 xmem_a  output  ADDR_W  activation/weight SRAM address.
REQ-009 pmem_cen_n, pmem_wen_n  output  1 each  psum SRAM controls, active-low.
REQ-010 pmem_a  output  ADDR_W  psum SRAM address.
REQ-011 l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd, execute, load  output  1 each  datapath strobes.
REQ-012 acc, sfu_passthrough, pmem_ren, debug  output  1 each  SFU and psum read controls.
REQ-013 err  output  4  sticky error flags.
REQ-014 exec_cnt, orow_cnt  output  8 each  issued-execute and OFIFO-row-read counters.

Function
REQ-015 Each rising edge SHALL capture inst; every stage-1 output SHALL follow inst with exactly 1 cycle latency.
REQ-016 Stage-1 outputs: xmem_*, l0_wr, l0_rd, ififo_wr, ififo_rd, execute, load, acc, sfu_passthrough, debug.
REQ-017 ofifo_rd SHALL be registered as inst[6] AND ofifo_valid, sampled in the same cycle; rd while !valid SHALL NOT pass through.
REQ-018 A pmem write request (inst[32]=0 and inst[31]=1) SHALL enter a SFU_LAT-deep delay line carrying A_pmem.
REQ-019 At the delay-line head, the request SHALL assert pmem_cen_n=0 and pmem_wen_n=0 with the delayed address. Total latency from inst = 1+SFU_LAT cycles.
REQ-020 A pmem read (inst[32]=0, inst[31]=0) SHALL drive pmem_cen_n=0, pmem_wen_n=1, pmem_a=A_pmem and pmem_ren=inst[35] at stage 1.
REQ-021 Stage-1 read and delay-line-head write in the same cycle: write SHALL win, read SHALL be dropped, err[2] SHALL set.
REQ-022 No pmem access in a cycle: pmem_cen_n=1, pmem_wen_n=1, pmem_a holds its last value.
REQ-023 Back-to-back write requests SHALL each emerge in order, one per cycle, with no loss.
REQ-024 Sticky error flags, set at capture:
- err[0]: load and execute both 1.
- err[1]: xmem write (CEN=0, WEN=0) with l0_wr=1.
- err[2]: pmem collision (REQ-021).
- err[3]: inst[6]=1 while ofifo_valid=0.
REQ-025 Illegal instructions SHALL still be forwarded unchanged, except for the ofifo_rd gating (REQ-017) and collision resolution (REQ-021).
REQ-026 exec_cnt SHALL increment per captured execute=1; orow_cnt SHALL increment per issued ofifo_rd. Both saturate at 255 and do not wrap.

Reset
REQ-027 On reset assertion, asynchronously:
- xmem_cen_n=1, xmem_wen_n=1, pmem_cen_n=1, pmem_wen_n=1.
- All strobes 0; addresses 0; err=0; counters 0.
- Delay line flushed.
REQ-028 Reset mid-operation SHALL discard all in-flight pmem writes; none SHALL reach the outputs after release.
REQ-029 The first instruction captured after reset release SHALL appear on the stage-1 outputs 1 cycle later.

Verification
REQ-030 inst load=1 for 16 cycles -> load high exactly 16 cycles, starting 1 cycle later; err=0.
REQ-031 SFU_LAT=1; write request A_pmem=5, acc=1 -> acc=1 at cycle+1; pmem_cen_n=0, pmem_wen_n=0, pmem_a=5 at cycle+2.
REQ-032 Write to A_pmem=3, then next cycle read of A_pmem=7 (collision) -> write to 3 issued, read dropped, err=4'b0100.
REQ-033 ofifo_rd=1 with ofifo_valid=0, then with valid=1 -> ofifo_rd stays 0 then pulses once; err[3]=1; orow_cnt=1.
REQ-034 300 cycles of execute=1 -> exec_cnt=255, no wrap.
REQ-035 Write requests on 3 consecutive cycles, reset asserted before the last emerges -> outputs inactive immediately, no write after release, err=0, counters=0.
